// File: rtl/fp10_pkg.sv
// fp10_pkg: shared widths, encoding struct and saturation constant for the fp10 format.
// Rev 1.0
`default_nettype none

package fp10_pkg;

  localparam int EXP_W  = 4;
  localparam int FRAC_W = 6;
  localparam int SIG_W  = FRAC_W + 1;

  typedef struct packed {
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } fp10_t;

  localparam logic [EXP_W+FRAC_W-1:0] FP10_MAX = 10'h3FF;

endpackage

`default_nettype wire

// File: rtl/fp_round_rne.sv
// fp_round_rne: round-to-nearest-even of a normalized 1.f significand with GRS bits.
// Rev 1.0
`default_nettype none

module fp_round_rne
  import fp10_pkg::*;
(
  input  logic [SIG_W-1:0]  sig,
  input  logic [2:0]        grs,
  input  logic [EXP_W:0]    exp_in,
  output logic [FRAC_W-1:0] frac,
  output logic [EXP_W:0]    exp_out
);

  localparam logic [EXP_W:0] EXP_ONE = {{EXP_W{1'b0}}, 1'b1};

  logic           round_up;
  logic [SIG_W:0] sig_rnd;

  always_comb begin
    // Round up above half, or exactly at half when the kept LSB is odd.
    round_up = grs[2] & (grs[1] | grs[0] | sig[0]);
    sig_rnd  = {1'b0, sig} + {{SIG_W{1'b0}}, round_up};
    if (sig_rnd[SIG_W]) begin
      frac    = sig_rnd[SIG_W-1:1];
      exp_out = exp_in + EXP_ONE;
    end else begin
      frac    = sig_rnd[FRAC_W-1:0];
      exp_out = exp_in;
    end
  end

endmodule

`default_nettype wire

// File: rtl/fp_add.sv
// fp_add: two-stage pipelined adder for unsigned fp10 (4-bit exp, 6-bit frac, implicit 1).
// Rev 1.0
`default_nettype none

module fp_add #(
  parameter int EXP_W  = 4,
  parameter int FRAC_W = 6
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic [EXP_W+FRAC_W-1:0] a,
  input  logic [EXP_W+FRAC_W-1:0] b,
  output logic                    out_valid,
  output logic [EXP_W+FRAC_W-1:0] s,
  output logic                    cout
);

  import fp10_pkg::fp10_t;
  import fp10_pkg::SIG_W;
  import fp10_pkg::FP10_MAX;

  localparam int W    = EXP_W + FRAC_W;
  localparam int PAD  = 2 ** EXP_W;
  localparam int SH_W = SIG_W + PAD;
  localparam logic [EXP_W:0] EXP_ONE = {{EXP_W{1'b0}}, 1'b1};

  // Stage 1: align and add
  logic [EXP_W-1:0] exp_a, exp_b, exp_big, exp_small, diff;
  logic [SIG_W-1:0] sig_a, sig_b, sig_big, sig_small;
  logic [SH_W-1:0]  aligned;
  logic [SIG_W:0]   sum_c;
  logic [2:0]       grs_c;

  always_comb begin
    exp_a = a[W-1:FRAC_W];
    exp_b = b[W-1:FRAC_W];
    sig_a = {1'b1, a[FRAC_W-1:0]};
    sig_b = {1'b1, b[FRAC_W-1:0]};
    if (exp_a >= exp_b) begin
      exp_big   = exp_a;
      exp_small = exp_b;
      sig_big   = sig_a;
      sig_small = sig_b;
    end else begin
      exp_big   = exp_b;
      exp_small = exp_a;
      sig_big   = sig_b;
      sig_small = sig_a;
    end
    diff = exp_big - exp_small;
    // Padding is wide enough that no bit ever falls off the bottom, so sticky is exact.
    aligned = {sig_small, {PAD{1'b0}}} >> diff;
    sum_c   = {1'b0, sig_big} + {1'b0, aligned[SH_W-1 -: SIG_W]};
    grs_c   = {aligned[PAD-1], aligned[PAD-2], |aligned[PAD-3:0]};
  end

  logic             s1_valid;
  logic [EXP_W-1:0] s1_exp;
  logic [SIG_W:0]   s1_sum;
  logic [2:0]       s1_grs;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_exp   <= '0;
      s1_sum   <= '0;
      s1_grs   <= '0;
    end else begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_exp <= exp_big;
        s1_sum <= sum_c;
        s1_grs <= grs_c;
      end
    end
  end

  // Stage 2: normalize, round, saturate
  logic [SIG_W-1:0]  norm_sig;
  logic [2:0]        norm_grs;
  logic [EXP_W:0]    norm_exp;
  logic [FRAC_W-1:0] rnd_frac;
  logic [EXP_W:0]    rnd_exp;
  logic              ovf;
  fp10_t             res;

  always_comb begin
    if (s1_sum[SIG_W]) begin
      norm_sig = s1_sum[SIG_W:1];
      norm_grs = {s1_sum[0], s1_grs[2], s1_grs[1] | s1_grs[0]};
      norm_exp = {1'b0, s1_exp} + EXP_ONE;
    end else begin
      norm_sig = s1_sum[SIG_W-1:0];
      norm_grs = s1_grs;
      norm_exp = {1'b0, s1_exp};
    end
  end

  fp_round_rne u_round (
    .sig     (norm_sig),
    .grs     (norm_grs),
    .exp_in  (norm_exp),
    .frac    (rnd_frac),
    .exp_out (rnd_exp)
  );

  always_comb begin
    ovf      = rnd_exp[EXP_W];
    res.exp  = rnd_exp[EXP_W-1:0];
    res.frac = rnd_frac;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      s         <= '0;
      cout      <= 1'b0;
    end else begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        s    <= ovf ? FP10_MAX : res;
        cout <= ovf;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fp_add.sv
// tb_fp_add: directed vectors with a scoreboard queue and decoupled output monitor.
// Rev 1.0
`default_nettype none

module tb_fp_add;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid = 1'b0;
  logic [9:0] a = '0;
  logic [9:0] b = '0;
  logic       out_valid;
  logic [9:0] s;
  logic       cout;

  fp_add #(.EXP_W(4), .FRAC_W(6)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .s         (s),
    .cout      (cout)
  );

  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  typedef struct {
    logic [9:0] va;
    logic [9:0] vb;
    logic [9:0] vs;
    logic       vc;
    int         due;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cycle);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (out_valid === 1'b1) begin
      if (q.size() == 0) begin
        check("unexpected_out_valid", 32'd1, 32'd0);
      end else begin
        e = q.pop_front();
        check("latency", cycle, e.due);
        check($sformatf("sum %h+%h", e.va, e.vb), {22'd0, s}, {22'd0, e.vs});
        check($sformatf("cout %h+%h", e.va, e.vb), {31'd0, cout}, {31'd0, e.vc});
      end
    end
  end

  task automatic send(input logic [9:0] va, input logic [9:0] vb,
                      input logic [9:0] vs, input logic vc);
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    a = va;
    b = vb;
    q.push_back('{va, vb, vs, vc, cycle + 2});
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_s", {22'd0, s}, 32'd0);
    check("reset_cout", {31'd0, cout}, 32'd0);
    rst_n = 1'b1;

    // Back-to-back stream
    send(10'h000, 10'h000, 10'h040, 1'b0);  // 1.0 + 1.0 = 2.0
    send(10'h020, 10'h080, 10'h098, 1'b0);  // 1.5 + 4.0 = 5.5
    send(10'h080, 10'h020, 10'h098, 1'b0);  // swapped
    send(10'h040, 10'h001, 10'h060, 1'b0);  // tie rounds down to even
    send(10'h180, 10'h001, 10'h181, 1'b0);  // below half rounds down
    send(10'h3C0, 10'h3C0, 10'h3FF, 1'b1);  // overflow saturates
    send(10'h3BF, 10'h3BF, 10'h3FF, 1'b0);  // largest non-overflow
    send(10'h3FF, 10'h000, 10'h3FF, 1'b0);  // d = 15, all sticky
    send(10'h000, 10'h3FF, 10'h3FF, 1'b0);  // swapped
    idle(2);
    send(10'h040, 10'h003, 10'h062, 1'b0);  // tie rounds up to even
    idle(4);
    check("hold_s", {22'd0, s}, 32'h062);
    check("hold_cout", {31'd0, cout}, 32'd0);

    // Reset with two operand pairs in flight
    send(10'h040, 10'h040, 10'h080, 1'b0);
    send(10'h080, 10'h080, 10'h0C0, 1'b0);
    @(posedge clk);
    #2;
    in_valid = 1'b0;
    check("inflight_out_valid", {31'd0, out_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_clear_out_valid", {31'd0, out_valid}, 32'd0);
    check("async_clear_s", {22'd0, s}, 32'd0);
    check("async_clear_cout", {31'd0, cout}, 32'd0);
    q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(5);

    send(10'h000, 10'h000, 10'h040, 1'b0);  // first after reset
    idle(5);
    check("queue_drained", q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
